// File: rtl/vx_wb_arb_pkg.sv
// rtl/vx_wb_arb_pkg.sv - shared constants, beat struct and helpers for the writeback arbiter
package vx_wb_arb_pkg;

  localparam int NUM_REQS    = 6;
  localparam int NUM_THREADS = 4;
  localparam int NW_BITS     = 2;
  localparam int XLEN        = 32;
  localparam int NR_BITS     = 5;

  localparam int IDX_W  = $clog2(NUM_REQS);
  localparam int DATA_W = NUM_THREADS * XLEN;

  // Commit source positions on the request vectors
  localparam int SRC_ALU = 0;
  localparam int SRC_LD  = 1;
  localparam int SRC_CSR = 2;
  localparam int SRC_SAU = 3;
  localparam int SRC_FPU = 4;
  localparam int SRC_GPU = 5;

  function automatic int cmt_size_w(input int n_threads);
    return $clog2(n_threads + 1);
  endfunction

  localparam int CMT_W = cmt_size_w(NUM_THREADS);

  typedef struct packed {
    logic [NW_BITS-1:0]     wid;
    logic [31:0]            pc;
    logic [NUM_THREADS-1:0] tmask;
    logic                   wb;
    logic [NR_BITS-1:0]     rd;
    logic [DATA_W-1:0]      data;
    logic                   eop;
  } beat_t;

  localparam logic [IDX_W:0] NREQ_EXT = (IDX_W + 1)'(NUM_REQS);

  // Reduce an index sum (both operands < NUM_REQS) modulo NUM_REQS
  function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W:0] s);
    return (s >= NREQ_EXT) ? IDX_W'(s - NREQ_EXT) : IDX_W'(s);
  endfunction

  function automatic logic [CMT_W-1:0] popcount(input logic [NUM_THREADS-1:0] m);
    logic [CMT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_THREADS; i++) cnt = cnt + CMT_W'(m[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/vx_rr_lock_arbiter.sv
// rtl/vx_rr_lock_arbiter.sv - round-robin grant with packet lock
module vx_rr_lock_arbiter
  import vx_wb_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQS-1:0]  valid,
  input  logic [NUM_REQS-1:0]  eop,
  input  logic                 load,
  output logic [NUM_REQS-1:0]  grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 fire
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             locked;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Pick the winner: locked owner only, else first valid scanning from rr_ptr
  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr;
    cand      = rr_ptr;
    found     = 1'b0;
    if (locked) begin
      grant_idx = lock_idx;
      found     = valid[lock_idx];
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        cand = rr_wrap({1'b0, rr_ptr} + (IDX_W + 1)'(k));
        if (!found && valid[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
    end
    fire = found & load;
    if (fire) grant[grant_idx] = 1'b1;
  end

  // Lock on a non-final beat; advance the pointer past the owner on its final beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      lock_idx <= '0;
      locked   <= 1'b0;
    end else if (fire) begin
      if (eop[grant_idx]) begin
        rr_ptr <= rr_wrap({1'b0, grant_idx} + (IDX_W + 1)'(1));
        locked <= 1'b0;
      end else begin
        locked   <= 1'b1;
        lock_idx <= grant_idx;
      end
    end
  end

endmodule

// File: rtl/vx_wb_arbiter.sv
// rtl/vx_wb_arbiter.sv - writeback port arbiter with registered output; optional WB_ARB_PERF_EN perf counters
module vx_wb_arbiter
  import vx_wb_arb_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  output logic [NUM_REQS-1:0]             req_ready,
  input  logic [NUM_REQS*NW_BITS-1:0]     req_wid,
  input  logic [NUM_REQS*32-1:0]          req_pc,
  input  logic [NUM_REQS*NUM_THREADS-1:0] req_tmask,
  input  logic [NUM_REQS-1:0]             req_wb,
  input  logic [NUM_REQS*NR_BITS-1:0]     req_rd,
  input  logic [NUM_REQS*DATA_W-1:0]      req_data,
  input  logic [NUM_REQS-1:0]             req_eop,
  input  logic                            wb_stall,
  output logic                            wb_valid,
  output logic [NW_BITS-1:0]              wb_wid,
  output logic [31:0]                     wb_pc,
  output logic [NUM_THREADS-1:0]          wb_tmask,
  output logic [NR_BITS-1:0]              wb_rd,
  output logic [DATA_W-1:0]               wb_data,
  output logic                            wb_eop,
  output logic                            cmt_valid,
`ifdef WB_ARB_PERF_EN
  output logic [CMT_W-1:0]                cmt_size,
  output logic [31:0]                     perf_conflict_cnt,
  output logic [31:0]                     perf_stall_cnt
`else
  output logic [CMT_W-1:0]                cmt_size
`endif
);

  logic             load;
  logic             fire;
  logic [IDX_W-1:0] grant_idx;
  beat_t            win;

  assign load = ~(wb_valid & wb_stall);

  vx_rr_lock_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .valid     (req_valid),
    .eop       (req_eop),
    .load      (load),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .fire      (fire)
  );

  // Select the winning source's beat fields
  always_comb begin
    win       = '0;
    win.wid   = req_wid[int'(grant_idx)*NW_BITS +: NW_BITS];
    win.pc    = req_pc[int'(grant_idx)*32 +: 32];
    win.tmask = req_tmask[int'(grant_idx)*NUM_THREADS +: NUM_THREADS];
    win.wb    = req_wb[grant_idx];
    win.rd    = req_rd[int'(grant_idx)*NR_BITS +: NR_BITS];
    win.data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    win.eop   = req_eop[grant_idx];
  end

  // Output stage: beat fields hold under stall, commit count is refreshed every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid  <= 1'b0;
      wb_wid    <= '0;
      wb_pc     <= '0;
      wb_tmask  <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_eop    <= 1'b0;
      cmt_valid <= 1'b0;
      cmt_size  <= '0;
    end else begin
      cmt_valid <= fire;
      cmt_size  <= fire ? popcount(win.tmask) : '0;
      if (load) begin
        wb_valid <= fire & win.wb;
        if (fire) begin
          wb_wid   <= win.wid;
          wb_pc    <= win.pc;
          wb_tmask <= win.tmask;
          wb_rd    <= win.rd;
          wb_data  <= win.data;
          wb_eop   <= win.eop;
        end
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  // Count contention cycles and downstream back-pressure cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_conflict_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (load && ($countones(req_valid) > 1)) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (wb_valid && wb_stall)                perf_stall_cnt    <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// tb/tb_vx_wb_arbiter.sv - scoreboard bench for vx_wb_arbiter
module tb_vx_wb_arbiter;

  localparam int N  = 6;
  localparam int T  = 4;
  localparam int DW = 128;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*2-1:0]  req_wid;
  logic [N*32-1:0] req_pc;
  logic [N*T-1:0]  req_tmask;
  logic [N-1:0]    req_wb;
  logic [N*5-1:0]  req_rd;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_eop;
  logic            wb_stall;
  logic            wb_valid;
  logic [1:0]      wb_wid;
  logic [31:0]     wb_pc;
  logic [T-1:0]    wb_tmask;
  logic [4:0]      wb_rd;
  logic [DW-1:0]   wb_data;
  logic            wb_eop;
  logic            cmt_valid;
  logic [2:0]      cmt_size;
`ifdef WB_ARB_PERF_EN
  logic [31:0]     perf_conflict_cnt;
  logic [31:0]     perf_stall_cnt;
`endif

  vx_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wid   (req_wid),
    .req_pc    (req_pc),
    .req_tmask (req_tmask),
    .req_wb    (req_wb),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_eop   (req_eop),
    .wb_stall  (wb_stall),
    .wb_valid  (wb_valid),
    .wb_wid    (wb_wid),
    .wb_pc     (wb_pc),
    .wb_tmask  (wb_tmask),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_eop    (wb_eop),
    .cmt_valid (cmt_valid),
`ifdef WB_ARB_PERF_EN
    .cmt_size  (cmt_size),
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`else
    .cmt_size  (cmt_size)
`endif
  );

  logic          s_valid [N];
  logic [1:0]    s_wid   [N];
  logic [31:0]   s_pc    [N];
  logic [T-1:0]  s_tmask [N];
  logic          s_wb    [N];
  logic [4:0]    s_rd    [N];
  logic [DW-1:0] s_data  [N];
  logic          s_eop   [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = s_valid[i];
      req_wid[i*2 +: 2]       = s_wid[i];
      req_pc[i*32 +: 32]      = s_pc[i];
      req_tmask[i*T +: T]     = s_tmask[i];
      req_wb[i]               = s_wb[i];
      req_rd[i*5 +: 5]        = s_rd[i];
      req_data[i*DW +: DW]    = s_data[i];
      req_eop[i]              = s_eop[i];
    end
  end

  typedef struct {
    logic          wbv;
    logic [1:0]    wid;
    logic [4:0]    rd;
    logic [31:0]   pc;
    logic [T-1:0]  tmask;
    logic [DW-1:0] data;
    logic          eop;
    logic [2:0]    size;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [T-1:0] tm, input logic wb, input logic eop);
    s_valid[i] = v;
    s_wid[i]   = 2'(i);
    s_rd[i]    = rd;
    s_pc[i]    = pc;
    s_tmask[i] = tm;
    s_wb[i]    = wb;
    s_eop[i]   = eop;
    s_data[i]  = {pc, ~pc, pc + 32'd7, 27'd0, rd};
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) drive(i, 1'b0, 5'd0, 32'd0, '0, 1'b0, 1'b0);
  endtask

  // Record what the currently granted source should produce next cycle
  task automatic expect_src(input int i);
    exp_t e;
    e.wbv   = s_wb[i];
    e.wid   = s_wid[i];
    e.rd    = s_rd[i];
    e.pc    = s_pc[i];
    e.tmask = s_tmask[i];
    e.data  = s_data[i];
    e.eop   = s_eop[i];
    e.size  = 3'($countones(s_tmask[i]));
    q.push_back(e);
  endtask

  task automatic settle_ready(input string tag, input logic [N-1:0] exp);
    #1;
    chk(tag, req_ready, exp);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("cmt_valid", cmt_valid, 1'b1);
      chk("cmt_size", cmt_size, e.size);
      chk("wb_valid", wb_valid, e.wbv);
      if (e.wbv) begin
        chk("wb_wid", wb_wid, e.wid);
        chk("wb_rd", wb_rd, e.rd);
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_tmask", wb_tmask, e.tmask);
        chk("wb_data", wb_data, e.data);
        chk("wb_eop", wb_eop, e.eop);
      end
    end else begin
      chk("idle_cmt_valid", cmt_valid, 1'b0);
    end
  endtask

  initial begin
    reset    = 1'b0;
    wb_stall = 1'b0;
    idle_all();
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_cmt_valid", cmt_valid, 1'b0);
    chk("rst_cmt_size", cmt_size, 3'd0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, '0);
    tick();
    tick();
    reset = 1'b1;

    // Two single-beat sources: 0 then 2
    drive(0, 1'b1, 5'd1, 32'h100, 4'hF, 1'b1, 1'b1);
    drive(2, 1'b1, 5'd2, 32'h200, 4'h7, 1'b1, 1'b1);
    settle_ready("rr_first_src0", 6'b000001);
    expect_src(0);
    tick();
    drive(0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    settle_ready("rr_then_src2", 6'b000100);
    expect_src(2);
    tick();
    idle_all();
    settle_ready("rr_idle", 6'b000000);
    tick();

    // Locked 3-beat packet from source 1 with source 3 waiting
    drive(1, 1'b1, 5'd10, 32'h110, 4'h3, 1'b1, 1'b0);
    settle_ready("lock_beat0", 6'b000010);
    expect_src(1);
    tick();
    drive(1, 1'b0, 5'd11, 32'h114, 4'h3, 1'b1, 1'b0);
    drive(3, 1'b1, 5'd13, 32'h300, 4'h1, 1'b1, 1'b1);
    settle_ready("lock_owner_idle", 6'b000000);
    tick();
    drive(1, 1'b1, 5'd11, 32'h114, 4'h3, 1'b1, 1'b0);
    settle_ready("lock_beat1", 6'b000010);
    expect_src(1);
    tick();
    drive(1, 1'b1, 5'd12, 32'h118, 4'hC, 1'b1, 1'b1);
    settle_ready("lock_beat2", 6'b000010);
    expect_src(1);
    tick();
    drive(1, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    settle_ready("after_lock_src3", 6'b001000);
    expect_src(3);
    tick();
    drive(3, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    drive(0, 1'b1, 5'd20, 32'h400, 4'h5, 1'b1, 1'b1);
    drive(4, 1'b1, 5'd24, 32'h440, 4'h6, 1'b1, 1'b1);
    settle_ready("rr_ptr_at4", 6'b010000);
    expect_src(4);
    tick();
    drive(4, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    settle_ready("rr_wrap_src0", 6'b000001);
    expect_src(0);
    tick();
    idle_all();

    // Downstream stall holds the output register
    drive(2, 1'b1, 5'd7, 32'h2A0, 4'hF, 1'b1, 1'b1);
    settle_ready("pre_stall_src2", 6'b000100);
    expect_src(2);
    tick();
    drive(2, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    drive(5, 1'b1, 5'd25, 32'h500, 4'h9, 1'b1, 1'b1);
    wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle_ready("stall_ready", 6'b000000);
      tick();
      chk("stall_wb_valid", wb_valid, 1'b1);
      chk("stall_wb_rd", wb_rd, 5'd7);
      chk("stall_wb_pc", wb_pc, 32'h2A0);
      chk("stall_cmt_size", cmt_size, 3'd0);
    end
    wb_stall = 1'b0;
    settle_ready("resume_src5", 6'b100000);
    expect_src(5);
    tick();
    idle_all();

    // Non-writing beat still commits; zero tmask is forwarded
    drive(4, 1'b1, 5'd30, 32'h4B0, 4'b1011, 1'b0, 1'b1);
    settle_ready("nowb_src4", 6'b010000);
    expect_src(4);
    tick();
    drive(4, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    drive(0, 1'b1, 5'd31, 32'h0C0, 4'b0000, 1'b1, 1'b1);
    settle_ready("zero_tmask_src0", 6'b000001);
    expect_src(0);
    tick();
    idle_all();

    // Asynchronous reset in the middle of a locked packet
    drive(5, 1'b1, 5'd15, 32'h5A0, 4'hF, 1'b1, 1'b0);
    settle_ready("pkt5_beat0", 6'b100000);
    expect_src(5);
    tick();
    drive(5, 1'b1, 5'd16, 32'h5A4, 4'hF, 1'b1, 1'b0);
    drive(3, 1'b1, 5'd17, 32'h3A0, 4'h2, 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_rst_wb_valid", wb_valid, 1'b0);
    chk("async_rst_cmt_valid", cmt_valid, 1'b0);
    chk("async_rst_wb_rd", wb_rd, 5'd0);
    chk("async_rst_wb_pc", wb_pc, 32'd0);
    tick();
    reset = 1'b1;
    drive(0, 1'b1, 5'd18, 32'h0A0, 4'h1, 1'b1, 1'b1);
    settle_ready("post_rst_src0", 6'b000001);
    expect_src(0);
    tick();
    drive(0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    settle_ready("post_rst_no_lock", 6'b001000);
    expect_src(3);
    tick();
    idle_all();
    tick();

`ifdef WB_ARB_PERF_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 5'(i + 1), 32'h1000 + 32'(i), 4'hF, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      settle_ready("burst_ready", 6'(1 << (k % N)));
      expect_src(k % N);
      tick();
    end
    chk("perf_conflict_cnt", perf_conflict_cnt, 32'd10);
    chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
    idle_all();
    tick();
`endif

    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_wb_arbiter.md
Name: vx_wb_arbiter

Overview:
- Shares the single register-file writeback port among NUM_REQS commit sources (ALU, LSU-load, CSR, SAU, FPU, GPU).
- Round-robin arbitration with packet lock, so multi-beat commits are never interleaved.
- One-cycle registered output stage with downstream stall.
- Also emits the registered per-cycle committed-thread count used to update CSRs.

Parameters:
- NUM_REQS, 6, number of commit sources; index 0 has highest priority after reset.
- NUM_THREADS, 4, threads per warp (tmask width).
- NW_BITS, 2, warp-id width.
- XLEN, 32, data width per thread.
- NR_BITS, 5, destination register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQS  per-source commit valid.
- req_ready  out  NUM_REQS  per-source accept; a beat fires on valid&ready.
- req_wid  in  NUM_REQS*NW_BITS  warp id.
- req_pc  in  NUM_REQS*32  PC.
- req_tmask  in  NUM_REQS*NUM_THREADS  thread mask.
- req_wb  in  NUM_REQS  beat writes the register file.
- req_rd  in  NUM_REQS*NR_BITS  destination register.
- req_data  in  NUM_REQS*NUM_THREADS*XLEN  per-thread data.
- req_eop  in  NUM_REQS  last beat of this source's commit packet.
- wb_stall  in  1  register file cannot accept this cycle.
- wb_valid  out  1  writeback beat valid (only for beats with wb=1).
- wb_wid, wb_pc, wb_tmask, wb_rd, wb_data, wb_eop  out  matching widths  registered beat fields.
- cmt_valid  out  1  a commit beat fired last cycle (wb=0 beats included).
- cmt_size  out  $clog2(NUM_THREADS+1)  popcount of the fired beat's tmask.

Behaviour:
- Reset (reset=0, asynchronous): wb_valid=0, cmt_valid=0, cmt_size=0, all wb_* fields=0, lock cleared, rr pointer=0. Takes effect immediately even mid-packet; no partial packet resumes after reset.
- load = ~(wb_valid & wb_stall). When load=0, all req_ready=0 and the output register holds.
- Unlocked grant:
  - Scan for the first valid request starting at the rr pointer, wrapping modulo NUM_REQS.
  - Exactly one req_ready is asserted, to the winner, and only if load=1.
  - If no request is valid, nothing fires.
- Locked grant (set by a fired beat with eop=0): only the locked source may receive ready. Other sources wait even when the locked source is invalid. The lock persists until that source fires a beat with eop=1.
- Pointer update: on a fired beat with eop=1 from source i, rr = (i+1) mod NUM_REQS and the lock clears. Non-eop beats do not move the pointer.
- Output register (1-cycle latency), loaded when load=1:
  - wb_valid <= fire & winner.wb.
  - wb_* fields <= winner fields when fire; otherwise held.
  - A beat with wb=0 fires and counts but produces wb_valid=0.
- Commit count: cmt_valid <= fire; cmt_size <= popcount(winner tmask) when fire, else 0. It is registered every cycle independent of load, so it is 0 during stall cycles.
- A tmask of all zeros is legal: it is forwarded with cmt_size=0.
- Throughput: one beat per cycle when wb_stall=0. The ready path is combinational from req_valid, wb_stall and state.
- A requester must keep its fields stable while valid&~ready (standard valid/ready). The arbiter does not check this.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- When defined, adds output perf_conflict_cnt (32 bits) and output perf_stall_cnt (32 bits).
  - perf_conflict_cnt increments each cycle with at least 2 req_valid bits set and load=1.
  - perf_stall_cnt increments each cycle with wb_valid&wb_stall.
  - Both counters wrap modulo 2^32 and reset to 0.
- When undefined, neither port nor counter exists, and arbitration behaviour is identical.

Decomposition:
- Shared package vx_wb_arb_pkg holds:
  - beat struct (wid, pc, tmask, wb, rd, data, eop) parameterised by the constants above;
  - the cmt_size width function $clog2(NUM_THREADS+1);
  - index constants for source positions (ALU=0, LD=1, CSR=2, SAU=3, FPU=4, GPU=5).
- One sub-module, vx_rr_lock_arbiter: rr pointer, lock state, one-hot grant. The top does the muxing, output register and popcount.

Test Plan:
- After reset, sources 0 and 2 are valid with eop=1, wb_stall=0 -> cycle 1 grants 0 and cycle 2 grants 2. wb_valid is seen one cycle after each fire, and wb_rd matches.
- Source 1 sends 3 beats (eop=0,0,1) while source 3 is continuously valid -> source 3's ready stays 0 for all 3 beats. Source 3 fires on the 4th cycle, and rr becomes 4 after that.
- wb_stall=1 for 3 cycles with wb_valid=1 -> wb_* holds, all req_ready=0, cmt_valid=0 and cmt_size=0 during stall. Resumes the cycle after wb_stall falls.
- Source 4 fires with wb=0, tmask=4'b1011 -> wb_valid=0, cmt_valid=1, cmt_size=3 next cycle.
- reset asserted after beat 1 of a locked 3-beat packet from source 5 -> outputs are 0 immediately. After release, source 0's request is granted first.
- With WB_ARB_PERF_EN: all 6 sources valid for 10 cycles with no stall -> perf_conflict_cnt=10 while the burst is in progress.
